uart_rx_monitor: RTL

Synthesizable 8N1 UART receiver with a byte FIFO for the Microwatt DV benches. It sits directly downstream of the Microwatt UART transmit pad (mprj_io[6]) and replaces behavioural serial capture. Benches can consume console bytes with a valid/ready handshake and count them, and framing errors and overflow are flagged in hardware.

---
 rtl/uart_rx_monitor.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_monitor.sv
// Purpose : 8N1 UART receiver feeding a byte FIFO, with sticky frame/overflow flags and a byte counter.
// Latency : byte visible on out_data two clocks after the stop-bit sample (push cycle, then registered write).
// Backpres: out_ready stalls the FIFO head; a good byte arriving while the FIFO is full is dropped and flagged.
//
// Ports:
//   clock, resetb         system clock (rising edge), asynchronous active-low reset
//   rx                    serial line, idle high, asynchronous to clock
//   clear                 synchronous flush of FIFO, sticky flags and byte_count
//   out_data/out_valid    FIFO head byte and non-empty indication
//   out_ready             consumer accept; a pop happens on out_valid && out_ready
//   frame_err, overflow   sticky error flags
//   byte_count            count of good bytes, including ones dropped on overflow

// Purpose : generic synchronous FIFO with wrap-bit pointers and a synchronous clear.
// Latency : a push is visible at out_data/out_valid after the writing edge.
// Backpres: a push into a full FIFO is accepted only alongside a same-cycle pop, otherwise reported on drop.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             full,
    output logic             drop
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             empty;
    logic             pop_fire;
    logic             push_fire;

    assign empty     = (wptr == rptr);
    assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop_fire  = pop && !empty;
    // A full FIFO can still take a byte when the head leaves in the same cycle.
    assign push_fire = push && (!full || pop_fire);
    assign drop      = push && !push_fire;

    assign out_valid = !empty;
    // Gate the head so the output reads zero whenever nothing is stored.
    assign out_data  = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_fire) wptr <= wptr + 1'b1;
            if (pop_fire)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push_fire && !clear) mem[wptr[AW-1:0]] <= push_data;
    end
endmodule

// Purpose : top-level UART receive monitor (synchronizer, bit FSM, FIFO, flags, counter).
// Latency : stop sample -> push next cycle -> out_valid on the edge after that.
// Backpres: out_ready pops the FIFO; a full FIFO drops the new byte and sets overflow.
module uart_rx_monitor #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic        rx,
    input  logic        clear,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        frame_err,
    output logic        overflow,
    output logic [15:0] byte_count
);
    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        rx_meta;
    logic        rx_s;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic [2:0]  idx;
    logic [2:0]  idx_nxt;
    logic [7:0]  shreg;
    logic [7:0]  shreg_nxt;
    logic        push;
    logic        push_nxt;
    logic        ferr_set;
    logic        fifo_full;
    logic        fifo_drop;

    // Flops reset to the idle level so a reset never looks like a start edge.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            push  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            shreg <= shreg_nxt;
            push  <= push_nxt;
        end
    end

    // Each sampling state counts cnt down to zero and samples rx_s in that cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        shreg_nxt = shreg;
        push_nxt  = 1'b0;
        ferr_set  = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt = START;
                    cnt_nxt   = HALF_M1;
                end
            end
            START: begin
                if (cnt == 16'd0) begin
                    if (rx_s) begin
                        // Line went back high before mid-bit: glitch, not a start bit.
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = DATA;
                        cnt_nxt   = FULL_M1;
                        idx_nxt   = 3'd0;
                    end
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            DATA: begin
                if (cnt == 16'd0) begin
                    // LSB arrives first, so shift right; after eight bits it sits in bit 0.
                    shreg_nxt = {rx_s, shreg[7:1]};
                    cnt_nxt   = FULL_M1;
                    if (idx == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            STOP: begin
                if (cnt == 16'd0) begin
                    if (rx_s) begin
                        push_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        ferr_set  = 1'b1;
                        state_nxt = BRK;
                    end
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            BRK: begin
                // Wait out a held-low line so it is not re-read as a stream of zero bytes.
                if (rx_s) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // shreg is untouched in IDLE/START, so it still holds the byte during the push cycle.
    uart_rx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .resetb    (resetb),
        .clear     (clear),
        .push      (push),
        .push_data (shreg),
        .pop       (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .full      (fifo_full),
        .drop      (fifo_drop)
    );

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
            byte_count <= '0;
        end else if (clear) begin
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
            byte_count <= '0;
        end else begin
            if (ferr_set)  frame_err <= 1'b1;
            if (fifo_drop) overflow  <= 1'b1;
            // Dropped bytes were still received correctly, so they are counted.
            if (push)      byte_count <= byte_count + 16'd1;
        end
    end

    logic unused_full;
    assign unused_full = fifo_full;
endmodule
